// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with round-robin grant and registered write port.
// Optional clear sweep (zero FIRST_REG..LAST_REG) compiled in with REGFILE_CLEAR_SWEEP_EN.
module regfile_write_arbiter #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 15
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req0,
  input  logic [3:0]  rd0,
  input  logic [15:0] d0,
  output logic        ack0,
  input  logic        req1,
  input  logic [3:0]  rd1,
  input  logic [15:0] d1,
  output logic        ack1,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        WE,
  output logic [3:0]  Rd,
  output logic [15:0] D
);

  localparam logic [3:0] FIRST = 4'(FIRST_REG);
  localparam logic [3:0] LAST  = 4'(LAST_REG);

  // Handshake: reqN/rdN/dN are held until ackN; ackN is a one-cycle pulse
  // registered at the edge where the request was granted.

  logic        sweep_go;   // sweep starts at this edge (first write issued)
  logic        in_sweep;   // a later sweep write is issued at this edge
  logic [3:0]  sweep_rd;

  logic        ptr_q, ptr_d;
  logic        we_d, ack0_d, ack1_d, busy_d, gnt1;
  logic [3:0]  rd_d;
  logic [15:0] d_d;

`ifdef REGFILE_CLEAR_SWEEP_EN
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= FIRST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // clr_busy still high at the edge after the last write blocks a restart.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_go = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_start && !clr_busy) begin
          sweep_go = 1'b1;
          if (FIRST != LAST) begin
            state_d = SWEEP;
            cnt_d   = 4'(FIRST_REG + 1);
          end
        end
      end
      SWEEP: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = FIRST;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_sweep = (state_q == SWEEP);
  assign sweep_rd = in_sweep ? cnt_q : FIRST;
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start;
  assign sweep_go = 1'b0;
  assign in_sweep = 1'b0;
  assign sweep_rd = FIRST;
`endif

  // ptr_q names the requester that wins a tie (the one not granted last).
  always_comb begin
    we_d   = 1'b0;
    rd_d   = Rd;
    d_d    = D;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    busy_d = 1'b0;
    ptr_d  = ptr_q;
    gnt1   = req1 && (!req0 || ptr_q);
    if (in_sweep || sweep_go) begin
      we_d   = 1'b1;
      rd_d   = sweep_rd;
      d_d    = 16'h0000;
      busy_d = 1'b1;
    end else if (req0 || req1) begin
      ptr_d = !gnt1;
      if (gnt1) begin
        ack1_d = 1'b1;
        if (rd1 != 4'd0) begin
          we_d = 1'b1;
          rd_d = rd1;
          d_d  = d1;
        end
      end else begin
        ack0_d = 1'b1;
        if (rd0 != 4'd0) begin
          we_d = 1'b1;
          rd_d = rd0;
          d_d  = d0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      WE       <= 1'b0;
      Rd       <= 4'd0;
      D        <= 16'h0000;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      clr_busy <= 1'b0;
      ptr_q    <= 1'b0;
    end else begin
      WE       <= we_d;
      Rd       <= rd_d;
      D        <= d_d;
      ack0     <= ack0_d;
      ack1     <= ack1_d;
      clr_busy <= busy_d;
      ptr_q    <= ptr_d;
    end
  end

endmodule
